breakout_game_ctrl: RTL and testbench

Parametrised game-control state machine for the VGA breakout design. It sequences new-game, play, new-ball and game-over phases and keeps the reserve-ball count, BCD score, high score, brick count and level. It drives the freeze control and brick-reload pulse into the graphics unit. The host feeds it hit, miss and start pulses plus a once-per-frame tick, and reads score and level for the 7-segment display.

---
 rtl/breakout_game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// Game-control FSM for the breakout design: it sequences the new-game, play, new-ball and game-over phases.
// It also keeps the reserve-ball count, BCD score, high score, brick count, level and the frame timers.
module breakout_game_ctrl #(
    parameter int LIVES        = 3,
    parameter int BALL_W       = 2,
    parameter int DIGITS       = 4,
    parameter int POINTS       = 1,
    parameter int BRICKS       = 32,
    parameter int BRICK_W      = 6,
    parameter int DELAY_FRAMES = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int TIMER_W      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  hit,
    input  logic                  miss,
    output logic [1:0]            state,
    output logic                  gra_still,
    output logic [BALL_W-1:0]     balls_left,
    output logic [BRICK_W-1:0]    bricks_left,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hi_score,
    output logic [3:0]            level,
    output logic                  brick_reload
);

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam logic [BALL_W-1:0]  BALLS_INIT  = BALL_W'(LIVES - 1);
    localparam logic [BRICK_W-1:0] BRICKS_INIT = BRICK_W'(BRICKS);
    localparam logic [TIMER_W-1:0] DELAY_INIT  = TIMER_W'(DELAY_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_INIT   = TIMER_W'(OVER_FRAMES);

    game_state_t                state_q, state_d;
    logic [BALL_W-1:0]          balls_q, balls_d;
    logic [BRICK_W-1:0]         bricks_q, bricks_d;
    logic [4*DIGITS-1:0]        score_q, score_d, score_inc, score_hit;
    logic [4*DIGITS-1:0]        hi_q, hi_d;
    logic [3:0]                 level_q, level_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic                       reload_q, reload_d;
    logic                       still_q;

    // Add POINTS with a per-digit decimal carry; a carry out of the top digit pins the score at all nines.
    function automatic logic [4*DIGITS-1:0] bcd_add(input logic [4*DIGITS-1:0] a);
        logic [4*DIGITS-1:0] r;
        logic [4:0]          sum;
        logic [4:0]          carry;
        r     = '0;
        carry = 5'(POINTS);
        for (int i = 0; i < DIGITS; i++) begin
            sum = {1'b0, a[4*i +: 4]} + carry;
            if (sum > 5'd9) begin
                r[4*i +: 4] = 4'(sum - 5'd10);
                carry       = 5'd1;
            end else begin
                r[4*i +: 4] = sum[3:0];
                carry       = 5'd0;
            end
        end
        if (carry != 5'd0) begin
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    assign score_inc = bcd_add(score_q);
    assign score_hit = hit ? score_inc : score_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= NEWGAME;
            balls_q  <= BALLS_INIT;
            bricks_q <= BRICKS_INIT;
            score_q  <= '0;
            hi_q     <= '0;
            level_q  <= 4'd1;
            timer_q  <= '0;
            reload_q <= 1'b0;
            still_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            balls_q  <= balls_d;
            bricks_q <= bricks_d;
            score_q  <= score_d;
            hi_q     <= hi_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            reload_q <= reload_d;
            still_q  <= (state_d != PLAY);
        end
    end

    always_comb begin
        state_d  = state_q;
        balls_d  = balls_q;
        bricks_d = bricks_q;
        score_d  = score_q;
        hi_d     = hi_q;
        level_d  = level_q;
        timer_d  = timer_q;
        reload_d = 1'b0;
        case (state_q)
            NEWGAME: begin
                if (start) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    balls_d  = BALLS_INIT;
                    bricks_d = BRICKS_INIT;
                    level_d  = 4'd1;
                    reload_d = 1'b1;
                end
            end
            PLAY: begin
                score_d = score_hit;
                // A hit that clears the level wins over a simultaneous miss.
                if (hit && bricks_q == BRICK_W'(1)) begin
                    state_d  = NEWBALL;
                    timer_d  = DELAY_INIT;
                    bricks_d = BRICKS_INIT;
                    level_d  = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                    reload_d = 1'b1;
                end else begin
                    if (hit) bricks_d = bricks_q - BRICK_W'(1);
                    if (miss) begin
                        if (balls_q == '0) begin
                            state_d = OVER;
                            timer_d = OVER_INIT;
                            if (score_hit > hi_q) hi_d = score_hit;
                        end else begin
                            state_d = NEWBALL;
                            timer_d = DELAY_INIT;
                            balls_d = balls_q - BALL_W'(1);
                        end
                    end
                end
            end
            NEWBALL: begin
                if (start && timer_q == '0) begin
                    state_d = PLAY;
                end else if (tick && timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            OVER: begin
                if (timer_q == '0) begin
                    state_d = NEWGAME;
                end else if (tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = NEWGAME;
        endcase
    end

    assign state        = state_q;
    assign gra_still    = still_q;
    assign balls_left   = balls_q;
    assign bricks_left  = bricks_q;
    assign score        = score_q;
    assign hi_score     = hi_q;
    assign level        = level_q;
    assign brick_reload = reload_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: directed game scenarios, a decimal-integer reference model checked every cycle,
// and literal checkpoints at the interesting moments.
module tb_breakout_game_ctrl;

    localparam int LIVES        = 3;
    localparam int BALL_W       = 2;
    localparam int DIGITS       = 4;
    localparam int POINTS       = 1;
    localparam int BRICKS       = 32;
    localparam int BRICK_W      = 6;
    localparam int DELAY_FRAMES = 60;
    localparam int OVER_FRAMES  = 180;
    localparam int TIMER_W      = 8;
    localparam int MAX_SCORE    = 9999;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  tick, start, hit, miss;
    logic [1:0]            state;
    logic                  gra_still;
    logic [BALL_W-1:0]     balls_left;
    logic [BRICK_W-1:0]    bricks_left;
    logic [4*DIGITS-1:0]   score, hi_score;
    logic [3:0]            level;
    logic                  brick_reload;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    breakout_game_ctrl #(
        .LIVES(LIVES), .BALL_W(BALL_W), .DIGITS(DIGITS), .POINTS(POINTS),
        .BRICKS(BRICKS), .BRICK_W(BRICK_W), .DELAY_FRAMES(DELAY_FRAMES),
        .OVER_FRAMES(OVER_FRAMES), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk), .rstn(rstn), .tick(tick), .start(start), .hit(hit), .miss(miss),
        .state(state), .gra_still(gra_still), .balls_left(balls_left),
        .bricks_left(bricks_left), .score(score), .hi_score(hi_score),
        .level(level), .brick_reload(brick_reload)
    );

    always #5 clk = ~clk;

    // Reference model: phases as small integers, score as a plain decimal number.
    int m_state, m_balls, m_bricks, m_score, m_hi, m_level, m_timer;
    bit m_reload;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int                  x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        int s;
        if (!rstn) begin
            m_state <= 0; m_balls <= LIVES - 1; m_bricks <= BRICKS; m_score <= 0;
            m_hi <= 0; m_level <= 1; m_timer <= 0; m_reload <= 1'b0;
        end else begin
            m_reload <= 1'b0;
            if (m_state == 0) begin
                if (start) begin
                    m_state <= 1; m_score <= 0; m_balls <= LIVES - 1;
                    m_bricks <= BRICKS; m_level <= 1; m_reload <= 1'b1;
                end
            end else if (m_state == 1) begin
                s = m_score;
                if (hit) s = (m_score + POINTS > MAX_SCORE) ? MAX_SCORE : m_score + POINTS;
                m_score <= s;
                if (hit && m_bricks == 1) begin
                    m_state <= 2; m_timer <= DELAY_FRAMES; m_bricks <= BRICKS;
                    m_level <= (m_level < 15) ? m_level + 1 : 15; m_reload <= 1'b1;
                end else begin
                    if (hit) m_bricks <= m_bricks - 1;
                    if (miss && m_balls == 0) begin
                        m_state <= 3; m_timer <= OVER_FRAMES;
                        if (s > m_hi) m_hi <= s;
                    end else if (miss) begin
                        m_state <= 2; m_timer <= DELAY_FRAMES; m_balls <= m_balls - 1;
                    end
                end
            end else if (m_state == 2) begin
                if (start && m_timer == 0) m_state <= 1;
                else if (tick && m_timer > 0) m_timer <= m_timer - 1;
            end else begin
                if (m_timer == 0) m_state <= 0;
                else if (tick) m_timer <= m_timer - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",        32'(state),        32'(m_state));
            check("gra_still",    32'(gra_still),    32'(m_state != 1));
            check("balls_left",   32'(balls_left),   32'(m_balls));
            check("bricks_left",  32'(bricks_left),  32'(m_bricks));
            check("score",        32'(score),        32'(to_bcd(m_score)));
            check("hi_score",     32'(hi_score),     32'(to_bcd(m_hi)));
            check("level",        32'(level),        32'(m_level));
            check("brick_reload", 32'(brick_reload), 32'(m_reload));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic s_start, input logic s_hit, input logic s_miss, input logic s_tick);
        start = s_start; hit = s_hit; miss = s_miss; tick = s_tick;
        cyc(1);
        start = 1'b0; hit = 1'b0; miss = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},     32'(state),        32'd0);
        check({tag, " gra_still"}, 32'(gra_still),    32'd1);
        check({tag, " balls"},     32'(balls_left),   32'd2);
        check({tag, " bricks"},    32'(bricks_left),  32'd32);
        check({tag, " score"},     32'(score),        32'h0000);
        check({tag, " hi_score"},  32'(hi_score),     32'h0000);
        check({tag, " level"},     32'(level),        32'd1);
        check({tag, " reload"},    32'(brick_reload), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; tick = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
        cyc(3);
        check_reset_values("reset");
        rstn = 1'b1;
        cmp_en = 1'b1;
        cyc(2);

        // First game: serve, score 12.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start state", 32'(state), 32'd1);
        check("start reload", 32'(brick_reload), 32'd1);
        check("start balls", 32'(balls_left), 32'd2);
        cyc(1);
        check("reload one cycle", 32'(brick_reload), 32'd0);
        repeat (12) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("score 12", 32'(score), 32'h0012);
        check("bricks 20", 32'(bricks_left), 32'd20);

        // Lose a ball; the launch is gated by the frame delay.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("miss state", 32'(state), 32'd2);
        check("miss balls", 32'(balls_left), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("early start", 32'(state), 32'd2);
        ticks(DELAY_FRAMES - 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start timer 1", 32'(state), 32'd2);
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        check("start with last tick", 32'(state), 32'd2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("launch", 32'(state), 32'd1);

        // Clear the level with a simultaneous miss.
        repeat (19) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("bricks 1", 32'(bricks_left), 32'd1);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("clear state", 32'(state), 32'd2);
        check("clear level", 32'(level), 32'd2);
        check("clear bricks", 32'(bricks_left), 32'd32);
        check("clear balls", 32'(balls_left), 32'd1);
        check("clear reload", 32'(brick_reload), 32'd1);
        check("clear score", 32'(score), 32'h0032);
        ticks(DELAY_FRAMES);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("score 40", 32'(score), 32'h0040);

        // Use up the remaining balls.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("balls 0", 32'(balls_left), 32'd0);
        ticks(DELAY_FRAMES);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("over state", 32'(state), 32'd3);
        check("over still", 32'(gra_still), 32'd1);
        check("over hi", 32'(hi_score), 32'h0040);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("over ignores start/hit", 32'(state), 32'd3);
        check("over score held", 32'(score), 32'h0040);
        ticks(OVER_FRAMES - 1);
        check("over before last tick", 32'(state), 32'd3);
        ticks(1);
        check("over timer zero", 32'(state), 32'd3);
        cyc(1);
        check("back to newgame", 32'(state), 32'd0);
        check("newgame score kept", 32'(score), 32'h0040);

        // Second game ends below the high score.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("new game score", 32'(score), 32'h0000);
        repeat (10) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            ticks(DELAY_FRAMES);
            pulse(1'b1, 1'b0, 1'b0, 1'b0);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("game2 over", 32'(state), 32'd3);
        check("game2 score", 32'(score), 32'h0010);
        check("hi kept", 32'(hi_score), 32'h0040);
        ticks(OVER_FRAMES);
        cyc(1);

        // Third game runs the score into saturation and the level to 15.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < MAX_SCORE; k++) begin
            pulse(1'b0, 1'b1, 1'b0, 1'b0);
            if (m_state == 2) begin
                ticks(DELAY_FRAMES);
                pulse(1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
        check("score 9999", 32'(score), 32'h9999);
        check("level 15", 32'(level), 32'd15);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("score saturates", 32'(score), 32'h9999);
        check("bricks after sat", 32'(bricks_left), 32'd16);

        // Asynchronous reset in the middle of a new-ball countdown.
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(10);
        check("countdown state", 32'(state), 32'd2);
        rstn = 1'b0;
        #1;
        check_reset_values("async reset");
        cyc(2);
        rstn = 1'b1;
        cyc(2);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
